// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared types and helpers for the LED fade block.
//               - fade_state_t : ramp state encoding
//               - calc_div     : prescaler divide ratio, clamped to >= 1
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        HOLD = 2'd2,
        FALL = 2'd3
    } fade_state_t;

    // Integer divide ratio, never below 1 so a prescaler always ticks.
    function automatic int calc_div(input longint freq, input longint rate);
        longint q;
        q = freq / rate;
        return (q < 64'sd1) ? 1 : int'(q);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_core.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_core
// Description : PWM generator. A free-running step prescaler advances
//               pwm_cnt; the duty shadow register is reloaded only when
//               pwm_cnt wraps, so every PWM period carries a single clean
//               pulse of constant width.
// Ports       : clk       - system clock
//               reset_n   - asynchronous active-low reset
//               duty_next - duty value sampled at each period boundary
//               led_out   - registered PWM output
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_core #(
    parameter int FREQ_HZ     = 100000000,
    parameter int PWM_FREQ_HZ = 1000,
    parameter int BRIGHT_W    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [BRIGHT_W-1:0] duty_next,
    output logic                led_out
);
    import led_pkg::*;

    localparam int STEP_DIV = calc_div(longint'(FREQ_HZ),
                                       longint'(PWM_FREQ_HZ) * (longint'(1) << BRIGHT_W));
    localparam int STEP_CW  = $clog2(STEP_DIV) + 1;
    localparam logic [STEP_CW-1:0] STEP_LAST = STEP_CW'(STEP_DIV - 1);

    logic [STEP_CW-1:0]  step_cnt;
    logic                step_tick;
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic [BRIGHT_W-1:0] duty_shadow;

    assign step_tick = (step_cnt == STEP_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_cnt    <= '0;
            pwm_cnt     <= '0;
            duty_shadow <= '0;
            led_out     <= 1'b0;
        end else begin
            step_cnt <= step_tick ? '0 : step_cnt + STEP_CW'(1);
            if (step_tick) begin
                pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
                // Reload only on the wrap to 0: the new duty starts a fresh period.
                if (pwm_cnt == '1) begin
                    duty_shadow <= duty_next;
                end
            end
            led_out <= (pwm_cnt < duty_shadow);
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_fade.sv
`default_nettype none
// ============================================================================
// Module      : led_fade
// Description : LED fader. Ramps an internal brightness level linearly toward
//               target = led_in ? brightness : 0, one step per fade tick, and
//               drives the LED pin with PWM at that level.
//               Optional macro LED_FADE_GAMMA_EN: the PWM duty becomes
//               (level*level) >> BRIGHT_W for a perceptually linear fade.
// Ports       : clk        - system clock
//               reset_n    - asynchronous active-low reset
//               led_in     - requested LED state (level)
//               brightness - target duty while led_in = 1
//               led_out    - PWM drive to the LED pin
//               busy       - high while a ramp is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module led_fade #(
    parameter int FREQ_HZ     = 100000000,
    parameter int PWM_FREQ_HZ = 1000,
    parameter int BRIGHT_W    = 8,
    parameter int FADE_MS     = 250
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                led_in,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic                led_out,
    output logic                busy
);
    import led_pkg::*;

    localparam int FADE_DIV = calc_div(longint'(FADE_MS) * (longint'(FREQ_HZ) / 1000),
                                       longint'(1) << BRIGHT_W);
    localparam int FADE_CW  = $clog2(FADE_DIV) + 1;
    localparam logic [FADE_CW-1:0] FADE_LAST = FADE_CW'(FADE_DIV - 1);

    logic [FADE_CW-1:0]  fade_cnt;
    logic                fade_tick;
    fade_state_t         state;
    fade_state_t         state_next;
    logic [BRIGHT_W-1:0] level;
    logic [BRIGHT_W-1:0] level_next;
    logic [BRIGHT_W-1:0] target;
    logic [BRIGHT_W-1:0] duty_next;

    assign fade_tick = (fade_cnt == FADE_LAST);
    assign target    = led_in ? brightness : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fade_cnt <= '0;
        end else begin
            fade_cnt <= fade_tick ? '0 : fade_cnt + FADE_CW'(1);
        end
    end

    // The ramp direction comes from the live target every cycle, so a target
    // change reverses the ramp from the current level and a coincident fade
    // tick already moves toward the new target. Stepping only while strictly
    // below/above the target makes the level saturate there.
    always_comb begin
        state_next = IDLE;
        level_next = level;
        if (level < target) begin
            state_next = RISE;
        end else if (level > target) begin
            state_next = FALL;
        end else if (level != '0) begin
            state_next = HOLD;
        end
        case (state_next)
            RISE:    if (fade_tick) level_next = level + BRIGHT_W'(1);
            FALL:    if (fade_tick) level_next = level - BRIGHT_W'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            level <= '0;
        end else begin
            state <= state_next;
            level <= level_next;
        end
    end

    assign busy = (state == RISE) || (state == FALL);

`ifdef LED_FADE_GAMMA_EN
    logic [2*BRIGHT_W-1:0] level_wide;
    logic [2*BRIGHT_W-1:0] level_sq;
    assign level_wide = {{BRIGHT_W{1'b0}}, level};
    assign level_sq   = level_wide * level_wide;
    assign duty_next  = level_sq[2*BRIGHT_W-1:BRIGHT_W];
`else
    assign duty_next  = level;
`endif

    led_pwm_core #(
        .FREQ_HZ     (FREQ_HZ),
        .PWM_FREQ_HZ (PWM_FREQ_HZ),
        .BRIGHT_W    (BRIGHT_W)
    ) u_pwm (
        .clk       (clk),
        .reset_n   (reset_n),
        .duty_next (duty_next),
        .led_out   (led_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_led_fade.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_fade
// Description : Self-checking bench for led_fade. Expected level steps are
//               queued when the inputs change and popped as the ramp moves;
//               PWM duty and pulse shape are measured on led_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_fade;
    import led_pkg::*;

    localparam int FREQ_HZ     = 1000000;
    localparam int PWM_FREQ_HZ = 1000;
    localparam int BRIGHT_W    = 4;
    localparam int FADE_MS     = 16;
    localparam int STEP_DIV    = 62;
    localparam int FADE_DIV    = 1000;
    localparam int PERIOD      = STEP_DIV * 16;

    logic                clk        = 1'b0;
    logic                reset_n    = 1'b0;
    logic                led_in     = 1'b0;
    logic [BRIGHT_W-1:0] brightness = '0;
    logic                led_out;
    logic                busy;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int last_level = 0;

    int   cyc_count = 0;
    int   last_rise = -1;
    int   high_len  = 0;
    int   runt_viol = 0;
    int   rise_cnt  = 0;
    logic prev_led  = 1'b0;

    always #5 clk = ~clk;

    led_fade #(
        .FREQ_HZ     (FREQ_HZ),
        .PWM_FREQ_HZ (PWM_FREQ_HZ),
        .BRIGHT_W    (BRIGHT_W),
        .FADE_MS     (FADE_MS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .led_in     (led_in),
        .brightness (brightness),
        .led_out    (led_out),
        .busy       (busy)
    );

    function automatic int gamma_ref(input int l);
`ifdef LED_FADE_GAMMA_EN
        return (l * l) >> BRIGHT_W;
`else
        return l;
`endif
    endfunction

    // One clock; samples on the falling edge and tracks PWM pulse shape.
    task automatic cyc();
        @(negedge clk);
        cyc_count++;
        if (led_out && !prev_led) begin
            if (last_rise >= 0 && ((cyc_count - last_rise) % PERIOD) != 0) runt_viol++;
            last_rise = cyc_count;
            high_len  = 0;
            rise_cnt++;
        end
        if (led_out) high_len++;
        if (!led_out && prev_led && (high_len % STEP_DIV) != 0) runt_viol++;
        prev_led = led_out;
    endtask

    task automatic track_clear();
        last_rise = -1;
        high_len  = 0;
        runt_viol = 0;
        rise_cnt  = 0;
        prev_led  = led_out;
    endtask

    task automatic push_seq(input int from, input int to);
        if (to > from) for (int v = from + 1; v <= to; v++) exp_q.push_back(v);
        else           for (int v = from - 1; v >= to; v--) exp_q.push_back(v);
    endtask

    task automatic wait_steps(input int n, input string name);
        for (int s = 0; s < n; s++) begin
            int waited;
            int exp_l;
            bit seen;
            waited = 0;
            seen   = 1'b0;
            while (!seen && waited < FADE_DIV + 10) begin
                cyc();
                waited++;
                if (int'(dut.level) != last_level) seen = 1'b1;
            end
            exp_l = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL %s step %0d: no level change in %0d clocks, level=%0d required=%0d",
                         name, s, waited, dut.level, exp_l);
            end else if (int'(dut.level) !== exp_l) begin
                errors++;
                $display("FAIL %s step %0d: level=%0d required=%0d", name, s, dut.level, exp_l);
            end
            last_level = int'(dut.level);
        end
    endtask

    task automatic measure_high(output int cnt);
        cnt = 0;
        for (int i = 0; i < PERIOD; i++) begin
            cyc();
            if (led_out) cnt++;
        end
    endtask

    task automatic check_duty(input int lvl, input string name);
        int hi;
        repeat (PERIOD + 10) cyc();
        measure_high(hi);
        checks++;
        if (hi !== gamma_ref(lvl) * STEP_DIV) begin
            errors++;
            $display("FAIL %s: high=%0d of %0d clocks required=%0d", name, hi, PERIOD,
                     gamma_ref(lvl) * STEP_DIV);
        end
    endtask

    task automatic check_busy(input logic expv, input string name);
        checks++;
        if (busy !== expv) begin
            errors++;
            $display("FAIL %s: busy=%b required=%b", name, busy, expv);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        led_in     = 1'b1;
        brightness = 4'd15;
        repeat (10) cyc();
        checks++;
        if (led_out !== 1'b0) begin errors++; $display("FAIL reset_led: led_out=%b required=0", led_out); end
        check_busy(1'b0, "reset_busy");
        checks++;
        if (int'(dut.level) !== 0) begin errors++; $display("FAIL reset_level: level=%0d required=0", dut.level); end
        reset_n    = 1'b1;
        last_level = 0;
        track_clear();
    endtask

    task automatic test_reset_mid();
        int w;
        push_seq(0, 7);
        wait_steps(7, "mid_rise");
        check_busy(1'b1, "mid_busy");
        w = 0;
        while (!led_out && w < PERIOD + 10) begin cyc(); w++; end
        checks++;
        if (led_out !== 1'b1) begin errors++; $display("FAIL mid_led_high: led_out=%b required=1", led_out); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (led_out !== 1'b0) begin errors++; $display("FAIL async_led: led_out=%b required=0", led_out); end
        check_busy(1'b0, "async_busy");
        checks++;
        if (int'(dut.level) !== 0) begin errors++; $display("FAIL async_level: level=%0d required=0", dut.level); end
        repeat (3) cyc();
        reset_n    = 1'b1;
        last_level = 0;
        track_clear();
    endtask

    task automatic test_rise();
        repeat (2) cyc();
        check_busy(1'b1, "rise_busy_start");
        push_seq(0, 15);
        wait_steps(15, "rise");
        check_busy(1'b1, "rise_busy_at_top");
        cyc();
        check_busy(1'b0, "rise_busy_end");
        check_duty(15, "rise_duty15");
    endtask

    task automatic test_brightness();
        brightness = 4'd8;
        push_seq(15, 8);
        wait_steps(7, "bright_to8");
        repeat (2) cyc();
        check_busy(1'b0, "bright_hold8");
        check_duty(8, "bright_duty8");
        brightness = 4'd3;
        push_seq(8, 3);
        wait_steps(5, "bright_to3");
        check_duty(3, "bright_duty3");
        track_clear();
        brightness = 4'd12;
        push_seq(3, 12);
        wait_steps(9, "bright_to12");
        repeat (2 * PERIOD) cyc();
        checks++;
        if (runt_viol !== 0) begin errors++; $display("FAIL no_runt: violations=%0d required=0", runt_viol); end
        checks++;
        if (rise_cnt < 9) begin errors++; $display("FAIL pulse_count: pulses=%0d required>=9", rise_cnt); end
        brightness = 4'd15;
        push_seq(12, 15);
        wait_steps(3, "bright_to15");
    endtask

    task automatic test_fall();
        led_in = 1'b0;
        repeat (2) cyc();
        check_busy(1'b1, "fall_busy_start");
        push_seq(15, 0);
        wait_steps(15, "fall");
        repeat (2) cyc();
        check_busy(1'b0, "fall_busy_end");
        checks++;
        if (dut.state !== IDLE) begin errors++; $display("FAIL fall_idle: state=%0d required=%0d", dut.state, IDLE); end
        check_duty(0, "fall_dark");
    endtask

    task automatic test_reversal();
        led_in     = 1'b1;
        brightness = 4'd15;
        push_seq(0, 5);
        wait_steps(5, "rev_up");
        led_in = 1'b0;
        push_seq(5, 4);
        wait_steps(1, "rev_turn");
        push_seq(4, 0);
        wait_steps(4, "rev_down");
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_rise();
        test_brightness();
        test_fall();
        test_reversal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
